// File: rtl/bus_pkg.sv
// Shared definitions for the memory-side bus responder: FSM state encoding,
// counter widths and the data value returned on a failed read.
package bus_pkg;

  typedef enum logic [2:0] {
    BusIdle,
    BusSetup,
    BusWait,
    BusDone,
    BusErr
  } bus_state_t;

  localparam logic [15:0] BUS_ERR_DATA = 16'hFFFF;

  // Wide enough for WAIT_CYCLES up to 15 and TIMEOUT up to 255.
  localparam int WAIT_W = 4;
  localparam int TO_W   = 8;

endpackage

// File: rtl/bus_wait_timer.sv
// Wait-state and timeout counters for one memory access. load arms both
// counters; run advances them while the responder sits in its WAIT state.
module bus_wait_timer
  import bus_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int TIMEOUT     = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic wait_done,
  output logic timeout
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

  assign wait_done = (wait_cnt_q == '0);
  assign timeout   = wait_done && (to_cnt_q == TO_LAST);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    to_cnt_d   = to_cnt_q;
    if (load) begin
      wait_cnt_d = WAIT_W'(WAIT_CYCLES);
      to_cnt_d   = '0;
    end else if (run) begin
      // Both counters stop at their end value instead of wrapping.
      if (!wait_done) begin
        wait_cnt_d = wait_cnt_q - WAIT_W'(1);
      end else if (to_cnt_q != TO_LAST) begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      to_cnt_q   <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder on the CPU system bus: latches an address, runs one
// read or write against an external memory with wait states and timeout.
module mem_bus_responder
  import bus_pkg::bus_state_t, bus_pkg::BUS_ERR_DATA;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 2,
  parameter int TIMEOUT     = 15
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic [DATA_W-1:0] SysBus,
  input  logic              Ale,
  input  logic              Read,
  input  logic              Write,
  output logic [DATA_W-1:0] DataIn,
  output logic              Rdy,
  output logic              BusErr,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData,
  output logic              MemCe,
  output logic              MemWe,
  input  logic              MemAck
);

  bus_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              is_wr_q, is_wr_d;
  logic              wait_done, timeout;

  bus_wait_timer #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .TIMEOUT     (TIMEOUT)
  ) u_timer (
    .clk       (Clock),
    .rst_n     (nReset),
    .load      (state_q == bus_pkg::BusSetup),
    .run       (state_q == bus_pkg::BusWait),
    .wait_done (wait_done),
    .timeout   (timeout)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    is_wr_d = is_wr_q;
    unique case (state_q)
      bus_pkg::BusIdle: begin
        if (Ale) addr_d = ADDR_W'(SysBus);
        // Write alongside Read or Ale has no defined data source: reject it.
        if (Write && (Read || Ale)) begin
          state_d = bus_pkg::BusErr;
          if (Read) rd_d = DATA_W'(BUS_ERR_DATA);
        end else if (Read) begin
          state_d = bus_pkg::BusSetup;
          is_wr_d = 1'b0;
        end else if (Write) begin
          state_d = bus_pkg::BusSetup;
          wdata_d = SysBus;
          is_wr_d = 1'b1;
        end
      end
      bus_pkg::BusSetup: state_d = bus_pkg::BusWait;
      bus_pkg::BusWait: begin
        if (wait_done && MemAck) begin
          state_d = bus_pkg::BusDone;
          if (!is_wr_q) rd_d = MemRData;
        end else if (timeout) begin
          state_d = bus_pkg::BusErr;
          if (!is_wr_q) rd_d = DATA_W'(BUS_ERR_DATA);
        end
      end
      bus_pkg::BusDone,
      bus_pkg::BusErr:   state_d = bus_pkg::BusIdle;
      default:           state_d = bus_pkg::BusIdle;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= bus_pkg::BusIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      is_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      is_wr_q <= is_wr_d;
    end
  end

  // Strobes decode straight from the state flop so reset drops them at once.
  assign MemCe    = (state_q == bus_pkg::BusSetup) || (state_q == bus_pkg::BusWait);
  assign MemWe    = MemCe && is_wr_q;
  assign Rdy      = (state_q == bus_pkg::BusDone) || (state_q == bus_pkg::BusErr);
  assign BusErr   = (state_q == bus_pkg::BusErr);
  assign DataIn   = rd_q;
  assign MemAddr  = addr_q;
  assign MemWData = wdata_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: directed cases plus random transactions whose
// completion cycle and result come from a transaction-level timing model.
module tb_mem_bus_responder;

  localparam int DATA_W      = 16;
  localparam int ADDR_W      = 16;
  localparam int WAIT_CYCLES = 2;
  localparam int TIMEOUT     = 15;

  logic              Clock = 1'b0;
  logic              nReset;
  logic [DATA_W-1:0] SysBus;
  logic              Ale, Read, Write;
  logic [DATA_W-1:0] DataIn;
  logic              Rdy, BusErr;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWData;
  logic [DATA_W-1:0] MemRData;
  logic              MemCe, MemWe, MemAck;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] last_data;

  mem_bus_responder #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .WAIT_CYCLES (WAIT_CYCLES),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .Clock    (Clock),
    .nReset   (nReset),
    .SysBus   (SysBus),
    .Ale      (Ale),
    .Read     (Read),
    .Write    (Write),
    .DataIn   (DataIn),
    .Rdy      (Rdy),
    .BusErr   (BusErr),
    .MemAddr  (MemAddr),
    .MemWData (MemWData),
    .MemRData (MemRData),
    .MemCe    (MemCe),
    .MemWe    (MemWe),
    .MemAck   (MemAck)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One bus transaction. d = number of zero-count WAIT cycles the memory
  // holds MemAck low before raising it; d >= TIMEOUT means it never answers.
  // Request at cycle T: SETUP T+1, countdown T+2..T+1+WAIT_CYCLES, and
  // completion in the cycle after the deciding WAIT cycle.
  task automatic run_txn(input bit is_wr, input bit ale_with_req,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] rdata, input int d);
    int          first_zero;
    int          kr;
    bit          err;
    logic [15:0] exp_data;
    err        = (d >= TIMEOUT);
    first_zero = WAIT_CYCLES + 2;
    kr         = WAIT_CYCLES + 3 + (err ? TIMEOUT - 1 : d);
    @(posedge Clock); #1;
    check_bit("idle_rdy", Rdy, 1'b0);
    check_bit("idle_ce", MemCe, 1'b0);
    Ale = 1'b1; SysBus = addr;
    MemAck = 1'($urandom); MemRData = 16'($urandom);
    if (is_wr || !ale_with_req) begin
      @(posedge Clock); #1;
      Ale = 1'b0;
      SysBus = is_wr ? wdata : 16'($urandom);
    end
    Read = !is_wr; Write = is_wr;
    for (int k = 1; k <= kr; k++) begin
      @(posedge Clock); #1;
      Ale = 1'b0; SysBus = 16'($urandom);
      if (k < first_zero) begin
        MemAck = 1'($urandom); MemRData = 16'($urandom);
      end else if (k - first_zero < d) begin
        MemAck = 1'b0; MemRData = 16'($urandom);
      end else begin
        MemAck = 1'b1; MemRData = rdata;
      end
      if (k < kr) begin
        check_bit("busy_ce", MemCe, 1'b1);
        check_bit("busy_we", MemWe, is_wr);
        check_bit("busy_rdy", Rdy, 1'b0);
        check("busy_addr", MemAddr, addr);
        check("busy_datain_held", DataIn, last_data);
        if (is_wr) check("busy_wdata", MemWData, wdata);
      end else begin
        exp_data = is_wr ? last_data : (err ? 16'hFFFF : rdata);
        check_bit("done_rdy", Rdy, 1'b1);
        check_bit("done_buserr", BusErr, err);
        check_bit("done_ce", MemCe, 1'b0);
        check_bit("done_we", MemWe, 1'b0);
        check("done_datain", DataIn, exp_data);
        last_data = exp_data;
        Read = 1'b0; Write = 1'b0; MemAck = 1'b0;
      end
    end
  endtask

  // Write together with Read or Ale is rejected without touching memory.
  task automatic illegal(input bit ale, input bit rd, input logic [15:0] bus);
    @(posedge Clock); #1;
    check_bit("ill_idle_ce", MemCe, 1'b0);
    Ale = ale; Read = rd; Write = 1'b1; SysBus = bus; MemAck = 1'b1;
    @(posedge Clock); #1;
    Ale = 1'b0; Read = 1'b0; Write = 1'b0; MemAck = 1'b0;
    check_bit("ill_rdy", Rdy, 1'b1);
    check_bit("ill_buserr", BusErr, 1'b1);
    check_bit("ill_ce", MemCe, 1'b0);
    check_bit("ill_we", MemWe, 1'b0);
    if (rd) last_data = 16'hFFFF;
    check("ill_datain", DataIn, last_data);
    @(posedge Clock); #1;
    check_bit("ill_after_rdy", Rdy, 1'b0);
    check_bit("ill_after_ce", MemCe, 1'b0);
  endtask

  initial begin
    // Reset with random inputs.
    nReset = 1'b0;
    SysBus = 16'($urandom); Ale = 1'($urandom); Read = 1'($urandom);
    Write = 1'($urandom); MemRData = 16'($urandom); MemAck = 1'($urandom);
    #13;
    check_bit("rst_ce", MemCe, 1'b0);
    check_bit("rst_we", MemWe, 1'b0);
    check_bit("rst_rdy", Rdy, 1'b0);
    check_bit("rst_buserr", BusErr, 1'b0);
    check("rst_datain", DataIn, 16'h0000);
    check("rst_addr", MemAddr, 16'h0000);
    check("rst_wdata", MemWData, 16'h0000);
    last_data = 16'h0000;
    SysBus = '0; Ale = 1'b0; Read = 1'b0; Write = 1'b0; MemRData = '0; MemAck = 1'b0;
    @(negedge Clock) nReset = 1'b1;

    // Directed read, write, timeout and ack-boundary cases.
    run_txn(1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 0);
    run_txn(1'b1, 1'b0, 16'h0100, 16'h1234, 16'h0000, 0);
    run_txn(1'b0, 1'b1, 16'h0055, 16'h0000, 16'h7777, 1000);
    run_txn(1'b0, 1'b1, 16'h0066, 16'h0000, 16'hA5A5, TIMEOUT - 1);
    run_txn(1'b1, 1'b0, 16'h0077, 16'h5A5A, 16'h0000, TIMEOUT);
    run_txn(1'b0, 1'b0, 16'h0088, 16'h0000, 16'h1357, 3);

    illegal(1'b0, 1'b1, 16'h4321);
    illegal(1'b1, 1'b0, 16'h0999);

    // Reset in the middle of a WAIT state.
    @(posedge Clock); #1;
    Ale = 1'b1; Read = 1'b1; SysBus = 16'h0200; MemAck = 1'b0;
    @(posedge Clock); #1;
    Ale = 1'b0;
    @(posedge Clock); #1;
    check_bit("midrst_pre_ce", MemCe, 1'b1);
    #2 nReset = 1'b0;
    #1;
    check_bit("midrst_ce", MemCe, 1'b0);
    check_bit("midrst_we", MemWe, 1'b0);
    check_bit("midrst_rdy", Rdy, 1'b0);
    check("midrst_addr", MemAddr, 16'h0000);
    Read = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    check_bit("midrst_hold_rdy", Rdy, 1'b0);
    last_data = 16'h0000;
    @(negedge Clock) nReset = 1'b1;
    run_txn(1'b0, 1'b0, 16'h0300, 16'h0000, 16'hCAFE, 1);

    // Random traffic.
    for (int i = 0; i < 30; i++) begin
      int d;
      case ($urandom_range(0, 5))
        0:       d = TIMEOUT + int'($urandom_range(0, 3));
        1:       d = TIMEOUT - 1;
        default: d = int'($urandom_range(0, 4));
      endcase
      run_txn(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), d);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge Clock); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
